// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Multi-cycle multiply/divide unit with architectural HI/LO registers. It sits
// beside the ALU in the EX stage. An operation is launched by start. The
// operands are latched at launch. The HI/LO result is written on the edge where
// busy falls.
//
// Optional feature macro: MULDIV_MADD_EN
//   Defined   : op 100 (madd) and op 101 (maddu) accumulate the product into
//               {hi,lo} and take MULT_CYCLES.
//   Undefined : ops 100/101 are reserved. They are no-ops and busy stays low.
//
// Parameters:
//   MULT_CYCLES - busy length of the multiply ops (1..31)
//   DIV_CYCLES  - busy length of the divide ops (1..31)
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-low reset
//   start  - launch the operation selected by op
//   op     - 000 mult, 001 multu, 010 div, 011 divu, 100 madd, 101 maddu
//   a, b   - forwarded rs / rt operands
//   mthi   - write wdata to HI (honoured only while idle)
//   mtlo   - write wdata to LO (honoured only while idle)
//   wdata  - MTHI/MTLO data
//   hi, lo - HI/LO registers
//   busy   - operation in flight
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
`ifdef MULDIV_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MADDU = 3'b101;
`endif

  localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES);

  state_t      state_r;
  logic [4:0]  cnt_r;
  logic [2:0]  op_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic        busy_r;

  logic        op_legal_s;
  logic [4:0]  load_cnt_s;
  logic        is_signed_s;
  logic [63:0] mul_a_s;
  logic [63:0] mul_b_s;
  logic [63:0] prod_s;
  logic        a_neg_s;
  logic        b_neg_s;
  logic [31:0] abs_a_s;
  logic [31:0] abs_b_s;
  logic        div_zero_s;
  logic [31:0] divisor_s;
  logic [31:0] uq_s;
  logic [31:0] ur_s;
  logic [31:0] quot_s;
  logic [31:0] rem_s;
  logic [63:0] result_s;
  logic        write_s;

  assign hi   = hi_r;
  assign lo   = lo_r;
  assign busy = busy_r;

  // Decode whether the incoming op may launch, and choose its busy length.
  always_comb begin
    op_legal_s = 1'b0;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: op_legal_s = 1'b1;
`ifdef MULDIV_MADD_EN
      OP_MADD, OP_MADDU:                  op_legal_s = 1'b1;
`endif
      default:                            op_legal_s = 1'b0;
    endcase
    if (op[2:1] == 2'b01) begin
      load_cnt_s = DIV_LOAD;
    end else begin
      load_cnt_s = MULT_LOAD;
    end
  end

  // Arithmetic on the latched operands. Op bit 0 clear means signed.
  // A 64x64 product of the sign- or zero-extended operands, truncated to
  // 64 bits, equals the signed or unsigned 32x32 product.
  // Signed division runs on magnitudes and fixes the signs afterwards, so
  // 0x80000000 / -1 gives quotient 0x80000000 and remainder 0.
  always_comb begin
    is_signed_s = ~op_r[0];
    if (is_signed_s) begin
      mul_a_s = {{32{a_r[31]}}, a_r};
      mul_b_s = {{32{b_r[31]}}, b_r};
    end else begin
      mul_a_s = {32'd0, a_r};
      mul_b_s = {32'd0, b_r};
    end
    prod_s     = mul_a_s * mul_b_s;

    a_neg_s    = is_signed_s & a_r[31];
    b_neg_s    = is_signed_s & b_r[31];
    abs_a_s    = a_neg_s ? (32'd0 - a_r) : a_r;
    abs_b_s    = b_neg_s ? (32'd0 - b_r) : b_r;
    div_zero_s = (b_r == 32'd0);
    // A dummy divisor keeps the divider defined; the result is discarded.
    divisor_s  = div_zero_s ? 32'd1 : abs_b_s;
    uq_s       = abs_a_s / divisor_s;
    ur_s       = abs_a_s % divisor_s;
    quot_s     = (a_neg_s ^ b_neg_s) ? (32'd0 - uq_s) : uq_s;
    rem_s      = a_neg_s ? (32'd0 - ur_s) : ur_s;

    case (op_r)
      OP_MULT, OP_MULTU: begin
        result_s = prod_s;
        write_s  = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        result_s = {rem_s, quot_s};
        write_s  = ~div_zero_s;
      end
`ifdef MULDIV_MADD_EN
      // The accumulate base is HI/LO as it stands at the completion edge.
      OP_MADD, OP_MADDU: begin
        result_s = {hi_r, lo_r} + prod_s;
        write_s  = 1'b1;
      end
`endif
      default: begin
        result_s = {hi_r, lo_r};
        write_s  = 1'b0;
      end
    endcase
  end

  // Control FSM, operand latches, cycle counter and HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 5'd0;
      op_r    <= 3'd0;
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // A move on the start edge lands now. The result overwrites it later.
          if (mthi) begin
            hi_r <= wdata;
          end
          if (mtlo) begin
            lo_r <= wdata;
          end
          if (start && op_legal_s) begin
            state_r <= ST_RUN;
            busy_r  <= 1'b1;
            cnt_r   <= load_cnt_s;
            op_r    <= op;
            a_r     <= a;
            b_r     <= b;
          end
        end
        ST_RUN: begin
          // start/mthi/mtlo are ignored here because the hazard unit stalls them.
          if (cnt_r == 5'd1) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            cnt_r   <= 5'd0;
            if (write_s) begin
              hi_r <= result_s[63:32];
              lo_r <= result_s[31:0];
            end
          end else begin
            cnt_r <= cnt_r - 5'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          cnt_r   <= 5'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//
// Directed, self-checking bench for muldiv_unit. Each launch pushes its
// expected {hi,lo} onto a scoreboard queue. The entry is popped and compared
// when busy falls. The bench also checks busy lengths, moves, ignored starts,
// reserved ops and an asynchronous reset in the middle of a divide.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  muldiv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wdata (wdata),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one start edge. Scramble a/b afterwards to show that the operands were latched.
  task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] exp);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    exp_q.push_back(exp);
    step();
    start = 1'b0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  // Count busy cycles and optionally inject a start+mthi while busy.
  // Then pop the scoreboard and compare it with {hi,lo}.
  task automatic finish_op(input string tag, input int exp_n, input int inject_at);
    int n;
    logic [63:0] exp;
    n = 0;
    check({tag, "_busy_rise"}, {63'd0, busy}, 64'd1);
    while (busy === 1'b1 && n < 200) begin
      if (n == inject_at) begin
        start = 1'b1;
        op    = 3'b001;
        a     = 32'h0000_0003;
        b     = 32'h0000_0003;
        mthi  = 1'b1;
        wdata = 32'hDEAD_BEEF;
      end
      step();
      start = 1'b0;
      mthi  = 1'b0;
      n++;
    end
    check({tag, "_busy_len"}, 64'(n), 64'(exp_n));
    exp = exp_q.pop_front();
    check({tag, "_hilo"}, {hi, lo}, exp);
  endtask

  task automatic move(input logic to_hi, input logic [31:0] d);
    mthi  = to_hi;
    mtlo  = ~to_hi;
    wdata = d;
    step();
    mthi  = 1'b0;
    mtlo  = 1'b0;
  endtask

  initial begin
    int highs;
    reset = 1'b0;
    start = 1'b0;
    op    = 3'b000;
    a     = 32'd0;
    b     = 32'd0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    wdata = 32'd0;

    #12;
    check("reset_hi",   {32'd0, hi}, 64'd0);
    check("reset_lo",   {32'd0, lo}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    step();
    reset = 1'b1;
    step();

    // mult -2 * 3 = -6
    launch(3'b000, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA);
    finish_op("mult", 5, -1);

    // multu 0xFFFFFFFF^2
    launch(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    finish_op("multu", 5, -1);

    // div -7 / 2: quotient -3, remainder -1
    launch(3'b010, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    finish_op("div_neg", 10, -1);

    // div overflow corner case
    launch(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000});
    finish_op("div_ovf", 10, -1);

    // divu 100 / 7: quotient 14, remainder 2
    launch(3'b011, 32'd100, 32'd7, {32'd2, 32'd14});
    finish_op("divu", 10, -1);

    // moves while idle
    move(1'b1, 32'h0000_1234);
    move(1'b0, 32'h0000_5678);
    check("mthi_mtlo", {hi, lo}, {32'h0000_1234, 32'h0000_5678});

    // divu by zero keeps HI/LO. A start+mthi in the middle is ignored.
    launch(3'b011, 32'd55, 32'd0, {32'h0000_1234, 32'h0000_5678});
    finish_op("divu_zero", 10, 3);

    // a move on the start edge lands first, and the result overwrites it later
    mthi  = 1'b1;
    wdata = 32'h0000_AAAA;
    launch(3'b000, 32'd2, 32'd3, {32'd0, 32'd6});
    check("move_on_start", {32'd0, hi}, {32'd0, 32'h0000_AAAA});
    finish_op("mult_after_move", 5, -1);

    // reserved op 110 does nothing
    op    = 3'b110;
    start = 1'b1;
    step();
    start = 1'b0;
    check("reserved_busy", {63'd0, busy}, 64'd0);
    check("reserved_hilo", {hi, lo}, {32'd0, 32'd6});

    // maddu with hi=0, lo=0xFFFFFFFF, a=b=1
    move(1'b1, 32'd0);
    move(1'b0, 32'hFFFF_FFFF);
`ifdef MULDIV_MADD_EN
    launch(3'b101, 32'd1, 32'd1, {32'd1, 32'd0});
    finish_op("maddu", 5, -1);
`else
    op    = 3'b101;
    a     = 32'd1;
    b     = 32'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    highs = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy !== 1'b0) highs++;
      step();
    end
    check("maddu_off_busy", 64'(highs), 64'd0);
    check("maddu_off_hilo", {hi, lo}, {32'd0, 32'hFFFF_FFFF});
`endif

    // asynchronous reset in cycle 4 of a divide. No late write may follow.
    move(1'b1, 32'h0BAD_0BAD);
    launch(3'b011, 32'd1000, 32'd3, 64'd0);
    void'(exp_q.pop_front());
    step();
    step();
    step();
    #2;
    reset = 1'b0;
    #1;
    check("midreset_busy", {63'd0, busy}, 64'd0);
    check("midreset_hilo", {hi, lo}, 64'd0);
    step();
    reset = 1'b1;
    highs = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (busy !== 1'b0) highs++;
    end
    check("postreset_busy", 64'(highs), 64'd0);
    check("postreset_hilo", {hi, lo}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers, instantiated beside the ALU in the EX stage.
- Consumes MulDiv/MThilo decode from the ID/EX register and forwarded rs/rt operands; produces HI/LO for MFHI/MFLO.
- Its busy output, together with the EX-stage start, drives the hazard unit's stall of any HI/LO-touching instruction in ID.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high for mult/multu (and madd/maddu when enabled); legal range 1-31.
- DIV_CYCLES, 10, cycles busy stays high for div/divu; legal range 1-31.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  launch the operation selected by op; sampled on a rising edge
- op  input  3  operation: 000 mult, 001 multu, 010 div, 011 divu, 100 madd, 101 maddu, 11x reserved
- a  input  32  rs operand, already forwarded
- b  input  32  rt operand, already forwarded
- mthi  input  1  write wdata to HI
- mtlo  input  1  write wdata to LO
- wdata  input  32  MTHI/MTLO data, rs forwarded
- hi  output  32  HI register
- lo  output  32  LO register
- busy  output  1  operation in flight

Behaviour:
- Reset (reset=0, asynchronous): hi=0, lo=0, busy=0, cycle counter=0, latched operands/op cleared. Any operation in flight is aborted with no HI/LO write.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, counter decrements each cycle.
- IDLE -> RUN on an edge with start=1 and a legal op:
  - op, a and b are latched.
  - Counter loads MULT_CYCLES or DIV_CYCLES.
  - busy rises after that edge and stays high for exactly N cycles.
- RUN -> IDLE on the edge where the counter reaches 1:
  - hi/lo update on that same edge; busy falls on that same edge.
  - New HI/LO values are visible in the first cycle busy=0.
- start while busy=1: ignored; the hazard unit guarantees it does not occur.
- start with a reserved op: no-op, stays IDLE.
- mult: {hi,lo} = signed(a) * signed(b), 64-bit result.
- multu: {hi,lo} = unsigned(a) * unsigned(b), 64-bit result.
- div: lo = quotient truncated toward zero; hi = remainder, sign follows the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu: unsigned quotient in lo, unsigned remainder in hi.
- Divide by zero (b=0, div or divu): full busy period still runs; hi/lo remain unchanged.
- mthi/mtlo in IDLE: written on the edge.
- mthi/mtlo while busy: ignored (stalled upstream).
- mthi/mtlo on the same edge as start: the move takes effect first; the operation result later overwrites it.
- Operands are latched at start, so later changes on a/b during RUN have no effect.
- hi/lo are plain register outputs with no combinational path from inputs.

Optional Feature:
- Macro: MULDIV_MADD_EN.
- Defined:
  - op 100 (madd): {hi,lo} = {hi,lo} + signed(a)*signed(b), modulo 2^64.
  - op 101 (maddu): {hi,lo} = {hi,lo} + unsigned(a)*unsigned(b), modulo 2^64.
  - Both take MULT_CYCLES.
  - The accumulate base is the HI/LO value at the completion edge.
- Not defined: ops 100/101 are treated as reserved (no-op, busy stays 0).

Test Plan:
- Reset low mid-div (cycle 4 of 10) -> busy=0 and hi=lo=0 immediately; after release, no late write occurs.
- start, op=000, a=0xFFFFFFFE (-2), b=3 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- start, op=001, a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- start, op=010, a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. Repeat with a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- mthi wdata=0x1234, mtlo wdata=0x5678 in IDLE; then divu b=0 -> after 10 busy cycles hi=0x1234, lo=0x5678. Second start asserted during busy -> ignored, busy length unchanged.
- MULDIV_MADD_EN defined: hi=0, lo=0xFFFFFFFF, maddu a=1, b=1 -> hi=1, lo=0. Undefined: the same op -> busy never asserts, hi/lo unchanged.
